// File: rtl/nn_pkg.sv
// Shared types and helpers for the NN datapath stages.
// Activation select codes and a width-generic saturating clamp.
package nn_pkg;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_RELU,
        ACT_LEAKY,
        ACT_RSVD
    } act_mode_e;

    localparam int SAT_MAXW = 64;

    // Clamp a sign-extended sum to the signed range of a dw-bit word.
    function automatic logic signed [SAT_MAXW:0] sat_clamp(
        input logic signed [SAT_MAXW:0] sum,
        input int                       dw
    );
        logic signed [SAT_MAXW:0] hi;
        logic signed [SAT_MAXW:0] lo;
        hi = (65'sd1 <<< (dw - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (dw - 1));
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/bias_act_pipe_if.sv
// Streaming bus for bias_act_pipe: input/output vector handshakes,
// bias file write port and saturation counter access.
interface bias_act_pipe_if
    import nn_pkg::*;
#(
    parameter int N_CH  = 10,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) ();

    localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data [N_CH];
    act_mode_e            act_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data [N_CH];
    logic                 bias_we;
    logic [AW-1:0]        bias_addr;
    logic signed [DW-1:0] bias_wdata;
    logic                 sat_clr;
    logic [CNT_W-1:0]     sat_count;

    modport master (
        output in_valid, in_data, act_mode, out_ready,
        output bias_we, bias_addr, bias_wdata, sat_clr,
        input  in_ready, out_valid, out_data, sat_count
    );

    modport slave (
        input  in_valid, in_data, act_mode, out_ready,
        input  bias_we, bias_addr, bias_wdata, sat_clr,
        output in_ready, out_valid, out_data, sat_count
    );

endinterface

// File: rtl/bias_sat_lane.sv
// One lane of the second stage: clamp the widened sum to DW bits,
// flag saturation, then apply the selected activation.
module bias_sat_lane
    import nn_pkg::*;
#(
    parameter int DW         = 32,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [DW:0]   sum,
    input  act_mode_e            mode,
    output logic signed [DW-1:0] res,
    output logic                 sat
);

    logic signed [SAT_MAXW:0] wide;
    logic signed [SAT_MAXW:0] clamped_w;
    logic signed [DW-1:0]     clamped;
    logic                     neg;

    always_comb begin
        wide      = {{(SAT_MAXW - DW){sum[DW]}}, sum};
        clamped_w = sat_clamp(wide, DW);
        clamped   = clamped_w[DW-1:0];
        sat       = (clamped_w != wide);
        neg       = clamped[DW-1];
        res       = clamped;
        unique case (1'b1)
            (neg && mode == ACT_RELU):  res = '0;
            (neg && mode == ACT_LEAKY): res = clamped >>> LEAK_SHIFT;
            default:                    res = clamped;
        endcase
    end

endmodule

// File: rtl/bias_act_pipe.sv
// Bias-add + saturate + activation stage: two-deep valid/ready
// pipeline with a writable per-lane bias file and a saturation counter.
module bias_act_pipe
    import nn_pkg::*;
#(
    parameter int N_CH       = 10,
    parameter int DW         = 32,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 16
) (
    input logic            clk,
    input logic            rst,
    bias_act_pipe_if.slave bus
);

    localparam int PW = $clog2(N_CH + 1);

    logic signed [DW-1:0] bias_q   [N_CH];
    logic signed [DW:0]   s1_sum   [N_CH];
    logic signed [DW-1:0] out_q    [N_CH];
    logic signed [DW-1:0] lane_res [N_CH];
    logic [N_CH-1:0]      lane_sat;
    act_mode_e            s1_mode;
    logic                 s1_valid;
    logic                 out_valid_q;
    logic [CNT_W-1:0]     sat_q;

    logic             s2_load;
    logic             s1_load;
    logic             accept;
    logic             bias_hit;
    logic [PW-1:0]    sat_pop;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        s2_load  = !out_valid_q || bus.out_ready;
        s1_load  = !s1_valid || s2_load;
        accept   = bus.in_valid && rst && s1_load;
        bias_hit = bus.bias_we && (int'(bus.bias_addr) < N_CH);
    end

    assign bus.in_ready  = rst && s1_load;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;
    assign bus.sat_count = sat_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        bias_sat_lane #(
            .DW         (DW),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .sum  (s1_sum[g]),
            .mode (s1_mode),
            .res  (lane_res[g]),
            .sat  (lane_sat[g])
        );
    end

    // Counter sticks at all-ones; a clear drops any same-cycle increment.
    always_comb begin
        sat_pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            sat_pop = sat_pop + PW'(lane_sat[i]);
        end
        cnt_sum = {1'b0, sat_q};
        if (s2_load && s1_valid) begin
            cnt_sum = cnt_sum + (CNT_W + 1)'(sat_pop);
        end
        if (bus.sat_clr) begin
            cnt_nxt = '0;
        end else if (cnt_sum[CNT_W]) begin
            cnt_nxt = '1;
        end else begin
            cnt_nxt = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid    <= 1'b0;
            out_valid_q <= 1'b0;
            s1_mode     <= ACT_NONE;
            sat_q       <= '0;
            for (int i = 0; i < N_CH; i++) begin
                bias_q[i] <= '0;
                s1_sum[i] <= '0;
                out_q[i]  <= '0;
            end
        end else begin
            // Accept reads bias_q before this edge's write lands.
            if (bias_hit) begin
                bias_q[bus.bias_addr] <= bus.bias_wdata;
            end
            if (s1_load) begin
                s1_valid <= accept;
            end
            if (accept) begin
                s1_mode <= bus.act_mode;
                for (int i = 0; i < N_CH; i++) begin
                    s1_sum[i] <= {bus.in_data[i][DW-1], bus.in_data[i]}
                               + {bias_q[i][DW-1], bias_q[i]};
                end
            end
            if (s2_load) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    out_q <= lane_res;
                end
            end
            sat_q <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_bias_act_pipe.sv
// Self-checking bench for bias_act_pipe: vector table, scoreboard
// and hand sequences for stalls, resets and counter corners.
module tb_bias_act_pipe;
    import nn_pkg::*;

    localparam int N_CH  = 10;
    localparam int DW    = 32;
    localparam int LEAK  = 3;
    localparam int CNT_W = 16;

    typedef logic [N_CH-1:0][DW-1:0] vec_t;

    typedef struct {
        int          lane;
        logic [DW-1:0] din;
        logic [DW-1:0] bias;
        logic [1:0]  mode;
        logic [DW-1:0] exp;
        int          exp_cnt;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;

    logic [DW-1:0] mbias [N_CH];
    vec_t sb_q[$];
    vec_t out_hist[$];

    bias_act_pipe_if #(.N_CH(N_CH), .DW(DW), .CNT_W(CNT_W)) bus ();

    bias_act_pipe #(
        .N_CH       (N_CH),
        .DW         (DW),
        .LEAK_SHIFT (LEAK),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model_lane(
        input logic [DW-1:0] x,
        input logic [DW-1:0] b,
        input logic [1:0]    m
    );
        longint s;
        longint hi;
        longint lo;
        s  = longint'($signed(x)) + longint'($signed(b));
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(longint'(1) << (DW - 1));
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        if (s < 0) begin
            if (m == 2'd1) s = 0;
            else if (m == 2'd2) s = s >>> LEAK;
        end
        return s[DW-1:0];
    endfunction

    function automatic vec_t model_vec(input vec_t v, input logic [1:0] m);
        vec_t r;
        for (int k = 0; k < N_CH; k++) begin
            r[k] = model_lane(v[k], mbias[k], m);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input vec_t act,
                           input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    initial begin : rdy_gen
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.out_ready = 1'b0;
                1: bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: push on accept, compare every valid cycle, pop on consume.
    initial begin : mon
        vec_t o;
        vec_t v;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb_q.delete();
                for (int k = 0; k < N_CH; k++) mbias[k] = '0;
            end else begin
                for (int k = 0; k < N_CH; k++) o[k] = bus.out_data[k];
                if (bus.out_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected", 64'(o[0]), 64'hDEAD);
                    end else begin
                        chk_vec("sb_data", o, sb_q[0]);
                        if (bus.out_ready) begin
                            out_hist.push_back(o);
                            void'(sb_q.pop_front());
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    for (int k = 0; k < N_CH; k++) v[k] = bus.in_data[k];
                    sb_q.push_back(model_vec(v, bus.act_mode));
                end
                if (bus.bias_we && int'(bus.bias_addr) < N_CH) begin
                    mbias[bus.bias_addr] = bus.bias_wdata;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input vec_t v, input logic [1:0] m);
        for (int k = 0; k < N_CH; k++) bus.in_data[k] = v[k];
        bus.act_mode = act_mode_e'(m);
    endtask

    task automatic send_vec(input vec_t v, input logic [1:0] m);
        bit ok;
        ok = 1'b0;
        set_in(v, m);
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            done = (sb_q.size() == 0) && !bus.out_valid;
        end
        if (!done) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic bias_wr(input int a, input logic [DW-1:0] d);
        bus.bias_we    = 1'b1;
        bus.bias_addr  = 4'(a);
        bus.bias_wdata = d;
        @(posedge clk);
        #1;
        bus.bias_we = 1'b0;
    endtask

    task automatic sat_clear();
        bus.sat_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.sat_clr = 1'b0;
    endtask

    initial begin : main
        rec_t tbl [11];
        vec_t v;
        vec_t z;
        int   n0;

        tbl[0]  = '{3, 32'hFFFFFFFE, 32'd5,        2'd0, 32'd3,        0};
        tbl[1]  = '{1, 32'h7FFFFFF0, 32'h20,       2'd0, 32'h7FFFFFFF, 1};
        tbl[2]  = '{2, 32'h80000000, 32'hFFFFFFFF, 2'd0, 32'h80000000, 2};
        tbl[3]  = '{4, 32'hFFFFFFF0, 32'd0,        2'd1, 32'd0,        2};
        tbl[4]  = '{5, 32'hFFFFFFF0, 32'd0,        2'd2, 32'hFFFFFFFE, 2};
        tbl[5]  = '{6, 32'hFFFFFFF0, 32'd0,        2'd3, 32'hFFFFFFF0, 2};
        tbl[6]  = '{7, 32'd100,      32'd0,        2'd1, 32'd100,      2};
        tbl[7]  = '{8, 32'hFFFFFFEF, 32'd0,        2'd2, 32'hFFFFFFFD, 2};
        tbl[8]  = '{9, 32'd7,        32'hFFFFFFF6, 2'd1, 32'd0,        2};
        tbl[9]  = '{0, 32'h80000000, 32'hFFFFFFFF, 2'd2, 32'hF0000000, 3};
        tbl[10] = '{1, 32'h7FFFFFFF, 32'd1,        2'd1, 32'h7FFFFFFF, 4};

        z = '0;
        bus.bias_we    = 1'b0;
        bus.bias_addr  = '0;
        bus.bias_wdata = '0;
        bus.sat_clr    = 1'b0;
        set_in(z, 2'd0);
        bus.in_valid = 1'b1;

        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
            chk("rst_sat_count", 64'(bus.sat_count), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        rdy_mode = 1;
        idle(2);

        send_vec(z, 2'd0);
        drain();
        chk_vec("bias_readback", out_hist[$], z);

        sat_clear();
        for (int i = 0; i < 11; i++) begin
            bias_wr(tbl[i].lane, tbl[i].bias);
            for (int k = 0; k < N_CH; k++) v[k] = DW'(k + 1);
            v[tbl[i].lane] = tbl[i].din;
            send_vec(v, tbl[i].mode);
            @(negedge clk);
            chk("lat_1clk", 64'(bus.out_valid), 64'd0);
            @(negedge clk);
            chk("lat_2clk", 64'(bus.out_valid), 64'd1);
            drain();
            chk($sformatf("tbl%0d_lane", i),
                64'(out_hist[$][tbl[i].lane]), 64'(tbl[i].exp));
            chk($sformatf("tbl%0d_satcnt", i),
                64'(bus.sat_count), 64'(tbl[i].exp_cnt));
            bias_wr(tbl[i].lane, '0);
        end

        bias_wr(12, 32'd77);
        send_vec(z, 2'd0);
        drain();
        chk_vec("bias_addr_oob", out_hist[$], z);

        v = '0;
        v[0] = 32'd10;
        bus.bias_we    = 1'b1;
        bus.bias_addr  = 4'd0;
        bus.bias_wdata = 32'd100;
        set_in(v, 2'd0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("bw_same_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.bias_we  = 1'b0;
        bus.in_valid = 1'b0;
        send_vec(v, 2'd0);
        drain();
        chk("bw_old_bias", 64'(out_hist[$-1][0]), 64'd10);
        chk("bw_new_bias", 64'(out_hist[$][0]), 64'd110);

        bias_wr(0, 32'h7FFFFFFF);
        sat_clear();
        v = '0;
        v[0] = 32'd100;
        send_vec(v, 2'd0);
        bus.sat_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.sat_clr = 1'b0;
        drain();
        chk("satclr_collide", 64'(bus.sat_count), 64'd0);
        send_vec(v, 2'd0);
        drain();
        chk("satclr_after", 64'(bus.sat_count), 64'd1);
        bias_wr(0, '0);

        n0 = out_hist.size();
        rdy_mode = 2;
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < N_CH; k++) v[k] = $urandom;
            if (i == 10) begin
                bus.bias_we    = 1'b1;
                bus.bias_addr  = 4'd5;
                bus.bias_wdata = DW'($urandom_range(0, 1000));
            end
            send_vec(v, 2'($urandom_range(0, 3)));
            bus.bias_we = 1'b0;
        end
        rdy_mode = 1;
        drain();
        chk("bp_count", 64'(out_hist.size() - n0), 64'd20);

        rdy_mode = 0;
        idle(2);
        for (int k = 0; k < N_CH; k++) v[k] = DW'(k * 3);
        send_vec(v, 2'd0);
        send_vec(v, 2'd1);
        @(negedge clk);
        chk("mid_full", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_in_ready", 64'(bus.in_ready), 64'd1);
        rdy_mode = 1;
        repeat (3) begin
            @(negedge clk);
            chk("mid_empty", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        for (int k = 0; k < N_CH; k++) bias_wr(k, 32'h7FFFFFFF);
        sat_clear();
        for (int k = 0; k < N_CH; k++) v[k] = 32'h7FFFFFFF;
        for (int i = 0; i < 6600; i++) send_vec(v, 2'd0);
        drain();
        chk("sat_cnt_cap", 64'(bus.sat_count), 64'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
